// File: rtl/input_fifo.sv
// input_fifo: router input-port flit buffer.
// Upstream handshake: CTS is a registered pulse raised one cycle after DRTS is
// seen (when there is room) and dropped on the accepting edge. This limits
// intake to one flit every two cycles and gives a write path that never looks
// at the read side. Any of the five output-port arbiter grants pops the head.
// Exactly one pop happens per cycle. If more than one grant was high in a
// cycle, err_multi_read reports it on the following cycle.
module input_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] RX,
    input  logic                  DRTS,
    input  logic                  read_en_N,
    input  logic                  read_en_E,
    input  logic                  read_en_W,
    input  logic                  read_en_S,
    input  logic                  read_en_L,
    output logic                  CTS,
    output logic [DATA_WIDTH-1:0] Data_out,
    output logic                  empty,
    output logic                  full,
    output logic                  err_multi_read
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    // Storage is deliberately left out of reset; only the bookkeeping is cleared.
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             cts_q, cts_d;
    logic             err_q, err_d;

    logic             any_rd;
    logic [2:0]       n_rd;
    logic             wr;
    logic             rd;

    assign empty    = (count_q == '0);
    assign full     = (count_q == CNT_W'(DEPTH));
    assign CTS      = cts_q;
    assign err_multi_read = err_q;
    assign Data_out = mem_q[rd_ptr_q];

    // Strobe decode.
    // The write side only uses DRTS, CTS and full, so it has no path from read_en.
    // The full guard cannot trigger in practice, because CTS is never raised
    // while full. It is kept so that an unexpected write still cannot corrupt
    // the buffer.
    // A read is gated by empty, so a write and a read that arrive together at
    // occupancy 0 act as a write only.
    always_comb begin
        any_rd = read_en_N | read_en_E | read_en_W | read_en_S | read_en_L;
        n_rd   = 3'(read_en_N) + 3'(read_en_E) + 3'(read_en_W)
               + 3'(read_en_S) + 3'(read_en_L);
        wr     = DRTS & cts_q & ~full;
        rd     = any_rd & ~empty;
    end

    // Next-state for pointers, occupancy, handshake and error flag.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        cts_d    = 1'b0;
        err_d    = (n_rd > 3'd1);

        // Power-of-two depth: natural overflow gives modulo-DEPTH wrap.
        if (wr) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (rd) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        case ({wr, rd})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        // CTS pulses high for one cycle and then returns low. It stays low
        // while full, even though DRTS remains asserted.
        if (DRTS && !cts_q && !full) begin
            cts_d = 1'b1;
        end
    end

    // Control registers; synchronous reset wins over any in-flight strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            cts_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            cts_q    <= cts_d;
            err_q    <= err_d;
        end
    end

    // Flit storage. The write is suppressed while reset is asserted, so a
    // handshake caught by reset leaves the array untouched.
    always_ff @(posedge clk) begin
        if (wr && !rst) begin
            mem_q[wr_ptr_q] <= RX;
        end
    end

endmodule

// File: tb/tb_input_fifo.sv
// Directed bench for input_fifo (DATA_WIDTH=32, DEPTH=4).
// Inputs are driven and outputs are sampled on the falling edge.
module tb_input_fifo;

    logic        clk;
    logic        rst;
    logic [31:0] RX;
    logic        DRTS;
    logic        read_en_N, read_en_E, read_en_W, read_en_S, read_en_L;
    logic        CTS;
    logic [31:0] Data_out;
    logic        empty, full, err_multi_read;

    int total = 0;
    int bad   = 0;

    input_fifo #(.DATA_WIDTH(32), .DEPTH(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .RX             (RX),
        .DRTS           (DRTS),
        .read_en_N      (read_en_N),
        .read_en_E      (read_en_E),
        .read_en_W      (read_en_W),
        .read_en_S      (read_en_S),
        .read_en_L      (read_en_L),
        .CTS            (CTS),
        .Data_out       (Data_out),
        .empty          (empty),
        .full           (full),
        .err_multi_read (err_multi_read)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        int sent;
        int popped;
        int cyc;
        logic will_wr;
        logic will_rd;

        rst = 1'b1; DRTS = 1'b0; RX = '0;
        read_en_N = 0; read_en_E = 0; read_en_W = 0; read_en_S = 0; read_en_L = 0;

        // Reset for two cycles.
        tick(); tick();
        chk("rst_cts",   32'(CTS), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full",  32'(full), 32'd0);
        chk("rst_err",   32'(err_multi_read), 32'd0);
        rst = 1'b0;

        // Fill: CTS pulses 0,1,0,1; full after four accepts; fifth flit refused.
        DRTS = 1'b1; RX = 32'hA1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("fill_cts_hi", 32'(CTS), 32'd1);
            tick();
            chk("fill_cts_lo", 32'(CTS), 32'd0);
            chk("fill_empty",  32'(empty), 32'd0);
            chk("fill_full",   32'(full), (i == 3) ? 32'd1 : 32'd0);
            chk("fill_head",   Data_out, 32'hA1);
            RX = 32'hA1 + 32'(i + 1);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("full_cts", 32'(CTS), 32'd0);
            chk("full_flag", 32'(full), 32'd1);
        end
        DRTS = 1'b0;

        // Drain with read_en_E: A1..A4 in order, then empty.
        read_en_E = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("drain_head",  Data_out, 32'hA1 + 32'(i));
            chk("drain_empty", 32'(empty), 32'd0);
            tick();
        end
        chk("drain_done_empty", 32'(empty), 32'd1);
        chk("drain_done_full",  32'(full), 32'd0);
        chk("drain_err",        32'(err_multi_read), 32'd0);
        // A read while empty must be ignored.
        tick();
        read_en_E = 1'b0;
        chk("rd_empty_ignored", 32'(empty), 32'd1);

        // Streaming 10 flits through the wrap; read_en_L follows ~empty.
        sent = 0; popped = 0; cyc = 0;
        while (popped < 10 && cyc < 200) begin
            DRTS      = (sent < 10);
            RX        = 32'hB0 + 32'(sent);
            read_en_L = ~empty;
            will_wr   = DRTS && CTS;
            will_rd   = read_en_L;
            chk("stream_empty", 32'(empty), (sent == popped) ? 32'd1 : 32'd0);
            chk("stream_full",  32'(full), 32'd0);
            if (will_rd) chk("stream_order", Data_out, 32'hB0 + 32'(popped));
            tick();
            if (will_wr) sent++;
            if (will_rd) popped++;
            cyc++;
        end
        DRTS = 1'b0; read_en_L = 1'b0;
        chk("stream_popped", 32'(popped), 32'd10);
        chk("stream_sent",   32'(sent), 32'd10);

        // One flit, two grants at once: one pop, error flag next cycle.
        DRTS = 1'b1; RX = 32'hC1;
        tick(); tick();
        DRTS = 1'b0;
        chk("dual_pre_empty", 32'(empty), 32'd0);
        chk("dual_pre_head",  Data_out, 32'hC1);
        read_en_N = 1'b1; read_en_S = 1'b1;
        tick();
        read_en_N = 1'b0; read_en_S = 1'b0;
        chk("dual_empty", 32'(empty), 32'd1);
        chk("dual_err",   32'(err_multi_read), 32'd1);
        tick();
        chk("dual_err_clr", 32'(err_multi_read), 32'd0);

        // Two flits, all five grants: still exactly one pop.
        DRTS = 1'b1; RX = 32'hC2;
        tick(); tick();
        RX = 32'hC3;
        tick(); tick();
        DRTS = 1'b0;
        chk("five_pre_head", Data_out, 32'hC2);
        read_en_N = 1; read_en_E = 1; read_en_W = 1; read_en_S = 1; read_en_L = 1;
        tick();
        read_en_N = 0; read_en_E = 0; read_en_W = 0; read_en_S = 0; read_en_L = 0;
        chk("five_head",  Data_out, 32'hC3);
        chk("five_empty", 32'(empty), 32'd0);
        chk("five_err",   32'(err_multi_read), 32'd1);

        // Reset mid-handshake with two flits queued.
        DRTS = 1'b1; RX = 32'hC4;
        tick(); tick();
        tick();
        chk("mid_cts_hi", 32'(CTS), 32'd1);
        chk("mid_full",   32'(full), 32'd0);
        RX = 32'hC5; rst = 1'b1;
        tick();
        rst = 1'b0; DRTS = 1'b0;
        chk("mid_rst_cts",   32'(CTS), 32'd0);
        chk("mid_rst_empty", 32'(empty), 32'd1);
        chk("mid_rst_full",  32'(full), 32'd0);
        chk("mid_rst_err",   32'(err_multi_read), 32'd0);

        // After reset the pointers agree: a fresh flit shows at the head.
        DRTS = 1'b1; RX = 32'hD1;
        tick(); tick();
        DRTS = 1'b0;
        chk("post_rst_empty", 32'(empty), 32'd0);
        chk("post_rst_head",  Data_out, 32'hD1);
        read_en_W = 1'b1;
        tick();
        read_en_W = 1'b0;
        chk("post_rst_pop_empty", 32'(empty), 32'd1);
        chk("post_rst_pop_err",   32'(err_multi_read), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/input_fifo.md
INPUT_FIFO -- requirements
Module: input_fifo

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, meaning the flit width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 4, meaning the number of flit slots (power of two, >=2).
REQ-003 The block SHALL have port clk, input, 1 bit, the clock, with all state updating on the rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit, a synchronous active-high reset.
REQ-005 The block SHALL have port RX, input, DATA_WIDTH bits, the flit from the upstream link.
REQ-006 The block SHALL have port DRTS, input, 1 bit, the upstream ready-to-send signal.
REQ-007 The block SHALL have ports read_en_N, read_en_E, read_en_W, read_en_S, read_en_L, each an input of 1 bit, the pop request from the output-port arbiters' grants.
REQ-008 The block SHALL have port CTS, output, 1 bit, the registered clear-to-send signal to upstream.
REQ-009 The block SHALL have port Data_out, output, DATA_WIDTH bits, the head flit.
REQ-010 The block SHALL have port empty, output, 1 bit, asserted when the occupancy is 0.
REQ-011 The block SHALL have port full, output, 1 bit, asserted when the occupancy equals DEPTH.
REQ-012 The block SHALL have port err_multi_read, output, 1 bit, registered, asserted when more than one read_en bit was high in the previous cycle.

Function
REQ-013 The block SHALL hold state in a DEPTH x DATA_WIDTH storage array, a read pointer, a write pointer and an occupancy counter of width log2(DEPTH)+1.
REQ-014 The write strobe SHALL be wr = DRTS & CTS, with RX written to mem[write_ptr] on that edge.
REQ-015 The next value of CTS SHALL be 1 iff DRTS=1, CTS=0 and full=0; otherwise it SHALL be 0, giving at most one accepted flit per two cycles.
REQ-016 The read strobe SHALL be rd = (read_en_N|read_en_E|read_en_W|read_en_S|read_en_L) & ~empty.
REQ-017 When several read_en bits are high in the same cycle, exactly one pop SHALL occur.
REQ-018 Data_out SHALL equal mem[read_ptr] combinationally, with zero-latency head visibility, and SHALL be don't-care while empty.
REQ-019 Both pointers SHALL increment modulo DEPTH on their strobe and wrap from DEPTH-1 to 0.
REQ-020 Occupancy SHALL change by +1 on wr only, -1 on rd only, and 0 on simultaneous wr and rd.
REQ-021 A write attempted while full SHALL be ignored, with pointer, count and memory unchanged; by construction of REQ-015 this is unreachable.
REQ-022 A read while empty SHALL be ignored, with no pointer or count change.
REQ-023 A simultaneous write and read at occupancy 0 SHALL be treated as a write only (rd=0), so occupancy becomes 1.
REQ-024 The read-side latency SHALL be such that a flit written at edge t is visible on Data_out and empty=0 after edge t, and is poppable in cycle t+1.
REQ-025 The write path SHALL NOT depend combinationally on any read_en input.

Reset
REQ-026 When rst=1 at a rising edge, the block SHALL clear read_ptr, write_ptr and count to 0, set CTS=0 and set err_multi_read=0.
REQ-027 Reset SHALL give priority over simultaneous wr and rd, so that in-flight flits are discarded.
REQ-028 The storage array SHALL NOT be cleared on reset.
REQ-029 After reset, the block SHALL drive empty=1 and full=0.
REQ-030 Reset asserted mid-handshake (CTS=1) SHALL suppress the write on that edge.

Verification
REQ-031 Scenario: with rst for 2 cycles -> CTS=0, empty=1, full=0 and err_multi_read=0.
REQ-032 Scenario: hold DRTS=1 with RX=0xA1,0xA2,... changing after each CTS pulse and no reads -> CTS toggles 0,1,0,1, and after 4 accepts full=1, CTS stays 0 and the 5th flit is not written.
REQ-033 Scenario: from full (0xA1..0xA4), pulse read_en_E for 4 cycles -> Data_out goes 0xA1,0xA2,0xA3,0xA4, then empty=1.
REQ-034 Scenario: drive continuous traffic of 10 flits with read_en_L high whenever empty=0 -> output order is preserved across pointer wrap and the count never exceeds 2.
REQ-035 Scenario: with 1 flit queued, assert read_en_N=read_en_S=1 for one cycle -> exactly one pop occurs, empty=1, and err_multi_read=1 on the next cycle.
REQ-036 Scenario: with 2 flits queued and CTS=1, DRTS=1 and rst=1 -> count=0 and CTS=0 after the edge, and no write occurs.
